// File: rtl/f_pkg.sv
// f_pkg: shared single-precision adder width and opcode constants
package f_pkg;
  localparam int FP_W = 32;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/f_sched_arb.sv
// f_sched_arb: one-hot grant among NREQ requests; round-robin from ptr under F_SCHED_RR_EN, else lowest index wins
module f_sched_arb #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
`ifdef F_SCHED_RR_EN
  input  logic [IDW-1:0]  ptr,
`endif
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);
  logic [IDW-1:0] j;
  logic found;
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef F_SCHED_RR_EN
      j = IDW'((int'(ptr) + k) % NREQ);
`else
      j = IDW'(k);
`endif
      if (en && req[j] && !found) begin
        found = 1'b1;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/f_adder_sched.sv
// f_adder_sched: shares one f_adder among NREQ requesters with credit-gated issue and a tagged response FIFO
// F_SCHED_RR_EN selects round-robin arbitration; undefined gives fixed priority (lowest index wins)
module f_adder_sched
  import f_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ADD_LAT = 1,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NREQ-1:0]  req_valid,
  output logic [NREQ-1:0]  req_ready,
  input  logic [NREQ*FP_W-1:0] req_in0,
  input  logic [NREQ*FP_W-1:0] req_in1,
  input  logic [NREQ-1:0]  req_op,
  output logic [FP_W-1:0]  adder_in0,
  output logic [FP_W-1:0]  adder_in1,
  output logic             adder_op,
  input  logic [FP_W-1:0]  adder_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [FP_W-1:0]  rsp_data,
  output logic             busy
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  if (ADD_LAT != 1) begin : g_lat_check
    $error("f_adder_sched supports ADD_LAT=1 only");
  end
  logic [IDW-1:0] mem_id [FIFO_DEPTH];
  logic [FP_W-1:0] mem_data [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [OW-1:0] room;
  logic inflight, pop, issue, allow;
  logic [IDW-1:0] inflight_id, gidx;
  logic [NREQ-1:0] gnt;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
`ifdef F_SCHED_RR_EN
  logic [IDW-1:0] rr_ptr;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) rr_ptr <= '0;
    else if (issue) rr_ptr <= (gidx == IDW'(NREQ - 1)) ? '0 : gidx + 1'b1;
`endif
  f_sched_arb #(.NREQ(NREQ)) u_arb (
    .req(req_valid),
    .en(allow),
`ifdef F_SCHED_RR_EN
    .ptr(rr_ptr),
`endif
    .gnt(gnt),
    .idx(gidx)
  );
  // a result popped this cycle frees a slot for the op issued this cycle
  always_comb begin
    rsp_valid = cnt != '0;
    pop = rsp_valid & rsp_ready;
    room = {1'b0, cnt} + OW'(inflight) - OW'(pop);
    allow = rstn && room < OW'(FIFO_DEPTH);
    issue = |gnt;
    req_ready = gnt;
    adder_in0 = issue ? req_in0[FP_W*gidx +: FP_W] : '0;
    adder_in1 = issue ? req_in1[FP_W*gidx +: FP_W] : '0;
    adder_op = issue ? req_op[gidx] : OP_ADD;
    rsp_id = rsp_valid ? mem_id[rp] : '0;
    rsp_data = rsp_valid ? mem_data[rp] : '0;
    busy = inflight | rsp_valid;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      inflight <= 1'b0;
      inflight_id <= '0;
    end else begin
      inflight <= issue;
      inflight_id <= issue ? gidx : inflight_id;
      cnt <= cnt + CW'(inflight) - CW'(pop);
      wp <= inflight ? inc(wp) : wp;
      rp <= pop ? inc(rp) : rp;
    end
  always_ff @(posedge clk)
    if (inflight) begin
      mem_id[wp] <= inflight_id;
      mem_data[wp] <= adder_out;
    end
  always_ff @(posedge clk)
    if (rstn) assert (!(inflight && !pop && cnt == CW'(FIFO_DEPTH))) else $error("response FIFO overflow");
endmodule

// File: tb/tb_f_adder_sched.sv
// tb_f_adder_sched: directed table-driven bench for f_adder_sched with a behavioural 1-cycle f_adder stand-in
module tb_f_adder_sched;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [NREQ-1:0] req_valid, req_ready, req_op;
  logic [NREQ*32-1:0] req_in0, req_in1;
  logic [31:0] adder_in0, adder_in1, adder_out;
  logic adder_op, rsp_valid, rsp_ready, busy;
  logic [IDW-1:0] rsp_id;
  logic [31:0] rsp_data;
  logic [31:0] a_v [NREQ];
  logic [31:0] b_v [NREQ];
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    int id;
    logic [31:0] a;
    logic [31:0] b;
    logic op;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [6];
  logic [31:0] one_to_four [4];
  logic [31:0] rr_res [4];
  logic [31:0] bp_a [6];
  logic [31:0] pb_a [4];
  logic [31:0] pb_d [4];
  int pb_id [4];
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < NREQ; i++) begin
      req_in0[32*i +: 32] = a_v[i];
      req_in1[32*i +: 32] = b_v[i];
    end
  f_adder_sched #(.NREQ(NREQ), .FIFO_DEPTH(2), .ADD_LAT(1)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in0(req_in0), .req_in1(req_in1), .req_op(req_op),
    .adder_in0(adder_in0), .adder_in1(adder_in1), .adder_op(adder_op),
    .adder_out(adder_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );
  function automatic logic [63:0] sp2dp(input logic [31:0] x);
    return (x[30:0] == 31'd0) ? {x[31], 63'd0} : {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
  endfunction
  function automatic logic [31:0] dp2sp(input logic [63:0] d);
    return (d[62:0] == 63'd0) ? 32'd0 : {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
  endfunction
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic op);
    real ra, rb;
    ra = $bitstoreal(sp2dp(a));
    rb = $bitstoreal(sp2dp(b));
    return dp2sp($realtobits(op ? ra - rb : ra + rb));
  endfunction
  always @(posedge clk) adder_out <= fadd(adder_in0, adder_in1, adder_op);
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic int rr_g(input int c);
`ifdef F_SCHED_RR_EN
    return c % NREQ;
`else
    return 0 + 0 * c;
`endif
  endfunction
  initial begin
    vecs[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
    vecs[1] = '{1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
    vecs[2] = '{2, 32'h40A00000, 32'h3F000000, 1'b0, 32'h40B00000};
    vecs[3] = '{3, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000};
    vecs[4] = '{0, 32'h41200000, 32'h41200000, 1'b1, 32'h00000000};
    vecs[5] = '{2, 32'hC0000000, 32'h40800000, 1'b0, 32'h40000000};
    one_to_four = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    rr_res = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    bp_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};
    pb_a = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
    pb_d = '{32'h00000000, 32'h3F800000, 32'h40400000, 32'h40800000};
    pb_id = '{1, 1, 2, 2};
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = 32'h3F800000;
      b_v[i] = 32'h3F800000;
    end
    req_op = '0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_adder_in0", adder_in0, 32'h0);
    tick();
    tick();
    req_valid = '0;
    rstn = 1'b1;
    foreach (vecs[v]) begin
      tick();
      a_v[vecs[v].id] = vecs[v].a;
      b_v[vecs[v].id] = vecs[v].b;
      req_op[vecs[v].id] = vecs[v].op;
      req_valid = 4'(1 << vecs[v].id);
      #1;
      chk("vec_req_ready", 32'(req_ready), 32'(1 << vecs[v].id));
      chk("vec_adder_in0", adder_in0, vecs[v].a);
      chk("vec_adder_in1", adder_in1, vecs[v].b);
      chk("vec_adder_op", 32'(adder_op), 32'(vecs[v].op));
      tick();
      req_valid = '0;
      #1;
      chk("vec_t1_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("vec_t1_busy", 32'(busy), 32'h1);
      chk("vec_idle_adder_in0", adder_in0, 32'h0);
      tick();
      #1;
      chk("vec_t2_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("vec_t2_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
      chk("vec_t2_rsp_data", rsp_data, vecs[v].exp);
    end
    tick();
    for (int i = 0; i < NREQ; i++) begin
      a_v[i] = one_to_four[i];
      b_v[i] = 32'h3F800000;
    end
    req_op = '0;
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) chk("rr_grant", 32'(req_ready), 32'(1 << rr_g(c)));
      if (c >= 2) begin
        chk("rr_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rr_rsp_id", 32'(rsp_id), 32'(rr_g(c - 2)));
        chk("rr_rsp_data", rsp_data, rr_res[rr_g(c - 2)]);
      end
      tick();
    end
    rsp_ready = 1'b0;
    req_op[1] = 1'b1;
    req_valid = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      a_v[1] = bp_a[c];
      #1;
      chk("bp_req_ready", 32'(req_ready), c < 2 ? 32'h2 : 32'h0);
      tick();
    end
    chk("bp_full_head_valid", 32'(rsp_valid), 32'h1);
    chk("bp_full_head_data", rsp_data, 32'h0);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_v[2] = pb_a[k];
      #1;
      chk("pp_req_ready", 32'(req_ready), 32'h4);
      chk("pp_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("pp_rsp_id", 32'(rsp_id), 32'(pb_id[k]));
      chk("pp_rsp_data", rsp_data, pb_d[k]);
      tick();
    end
    req_valid = '0;
    #1;
    chk("drain0_id", 32'(rsp_id), 32'h2);
    chk("drain0_data", rsp_data, 32'h40A00000);
    tick();
    #1;
    chk("drain1_id", 32'(rsp_id), 32'h2);
    chk("drain1_data", rsp_data, 32'h40C00000);
    tick();
    #1;
    chk("drain_busy", 32'(busy), 32'h0);
    chk("drain_rsp_valid", 32'(rsp_valid), 32'h0);
    a_v[3] = 32'h3F800000;
    b_v[3] = 32'h3F800000;
    req_valid = 4'b1000;
    #1;
    chk("mr_req_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    rstn = 1'b0;
    #1;
    chk("mr_busy_in_reset", 32'(busy), 32'h0);
    chk("mr_valid_in_reset", 32'(rsp_valid), 32'h0);
    tick();
    tick();
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("mr_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("mr_busy", 32'(busy), 32'h0);
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
